hex_digit_scan: RTL
===================

Name: hex_digit_scan

Overview:
Time-multiplexed scanner that feeds the single hex-to-7-segment decoder stage. It holds a multi-digit hex value loaded by strobe and steps through its nibbles at a prescaled rate. For each step it presents one nibble on `entrada` with the matching `modo` flag, and drives a one-hot active-low digit select so that one decoder drives all display positions. It also provides optional leading-zero suppression and a global display enable.

Parameters:
- NUM_DIGITS, 4: number of display positions; legal range 1..8.
- DIV, 50000: clock cycles per scan step; legal range >= 1.

Ports:
- clock, input, 1: system clock; all state changes on its rising edge.
- reset, input, 1: asynchronous, active-high reset; clears all state immediately.
- carregar, input, 1: load strobe; when sampled high, `valor` is latched.
- valor, input, 4*NUM_DIGITS: hex value; nibble i is valor[4i+3:4i], digit 0 is least significant.
- supressao, input, 1: 1 = leading-zero suppression enabled.
- ativo, input, 1: 0 = all digits report `modo`=0.
- entrada, output, 4: nibble of the currently selected digit, to the decoder.
- modo, output, 1: 1 = decoder shows the nibble; 0 = decoder shows its dash pattern.
- digito_sel, output, NUM_DIGITS: one-hot active-low position select; bit `indice` = 0.
- atualizado, output, 1: one-cycle pulse confirming a load.

Behaviour:
- State registers:
  - registrador: 4*NUM_DIGITS bits, the held value.
  - prescaler: counts 0..DIV-1; width clog2(DIV), minimum 1.
  - indice: 0..NUM_DIGITS-1.
  - atualizado.
- Reset, asynchronous (effective while `reset` is high, no clock needed): registrador=0, prescaler=0, indice=0, atualizado=0.
- Outputs after reset: digito_sel has only bit 0 low, entrada=0, modo=ativo.
- Prescaler:
  - Increments every clock.
  - At DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
  - DIV=1 gives a tick every cycle.
- Scan: on tick, indice <= (indice==NUM_DIGITS-1) ? 0 : indice+1. NUM_DIGITS=1 keeps indice at 0.
- Load:
  - On an edge with carregar=1: registrador <= valor, and atualizado <= 1. Otherwise atualizado <= 0.
  - carregar held high reloads every cycle, and atualizado stays high.
  - A load does not disturb prescaler or indice. The new value is visible on entrada the cycle after the edge.
- Outputs are combinational from registered state plus supressao/ativo. There is no additional latency, and a change of indice shows on entrada, modo and digito_sel in the same cycle.
  - entrada = registrador nibble[indice].
  - digito_sel = ~(1 << indice).
  - modo = 0 if ativo=0.
  - Otherwise, if supressao=1, indice>0, and every nibble from indice up to NUM_DIGITS-1 is zero: modo = 0.
  - Otherwise modo = 1.
  - Digit 0 is never suppressed, so value 0 displays a single "0".
- Simultaneous tick and carregar: both take effect on the same edge. The newly selected digit shows the newly loaded nibble in the next cycle.
- Reset asserted mid-scan or mid-load: all state clears at once and the pending load is discarded. Scanning restarts at digit 0 with a full DIV period.
- No X propagation: every indice value maps to a defined nibble.

Test Plan (DIV=4, NUM_DIGITS=4):
- Reset, then release with no load → digito_sel=1110, entrada=0, modo=1. Tick every 4 clocks; digito_sel sequence 1101, 1011, 0111, 1110.
- carregar for 1 cycle with valor=16'hA3F0 → atualizado high exactly 1 cycle. Across one scan, entrada = 0, F, 3, A for indices 0..3, with modo=1 on all.
- valor=16'h0070, supressao=1 → modo per index 0..3 is 1, 1, 0, 0. With supressao=0, all four are 1.
- valor=16'h0000, supressao=1 → only digit 0 has modo=1, entrada=0. With ativo=0, modo=0 on every index.
- carregar asserted on the same edge as the tick moving indice 2→3, valor=16'h5000 → next cycle digito_sel=0111, entrada=5; prescaler phase is unchanged.
- Assert reset at indice=2, prescaler=1 → immediately indice=0, registrador=0, atualizado=0. After release, the first tick occurs 4 clocks later.

Source files
------------

// File: rtl/hex_digit_scan.sv
// Time-multiplexed hex digit scanner: holds a multi-digit value and presents one
// nibble at a time, with its position select and blank flag, to a shared decoder.
module hex_digit_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 50000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    carregar,
    input  logic [4*NUM_DIGITS-1:0] valor,
    input  logic                    supressao,
    input  logic                    ativo,
    output logic [3:0]              entrada,
    output logic                    modo,
    output logic [NUM_DIGITS-1:0]   digito_sel,
    output logic                    atualizado
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] registrador;
    logic [PW-1:0]           prescaler;
    logic [IW-1:0]           indice;
    logic                    tick;
    logic                    blank_above;

    assign tick = (prescaler == PW'(DIV - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            indice    <= '0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick)
                indice <= (indice == IW'(NUM_DIGITS - 1)) ? '0 : indice + 1'b1;
        end
    end

    // Loading is independent of the scan, so a load never shifts the scan phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            registrador <= '0;
            atualizado  <= 1'b0;
        end else begin
            atualizado <= carregar;
            if (carregar)
                registrador <= valor;
        end
    end

    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        entrada     = 4'h0;
        digito_sel  = '1;
        blank_above = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (indice == IW'(i)) begin
                entrada       = registrador[4*i +: 4];
                digito_sel[i] = 1'b0;
            end
            if ((int'(indice) <= i) && (registrador[4*i +: 4] != 4'h0))
                blank_above = 1'b0;
        end
    end

    // Digit 0 is never suppressed, so an all-zero value still shows one "0".
    assign modo = ativo && !(supressao && (indice != '0) && blank_above);

endmodule
